// File: rtl/cmd_dispatcher_if.sv
// UART byte-stream bundle between the UART RX/TX blocks and the command dispatcher.
// master = UART side, slave = dispatcher side.
interface cmd_dispatcher_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_drop;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, rx_drop
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, rx_drop
    );
endinterface

// File: rtl/cmd_dispatcher.sv
// UART command dispatcher: opcode/argument parsing, threshold/frequency writes, triggered FFT peak readback.
// Optional feature macro: CMD_DISPATCH_ACK_EN (ACK byte after set commands and valid channel selection).
module cmd_dispatcher #(
    parameter int NUM_CH      = 4,
    parameter int VALUE_W     = 10,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    cmd_dispatcher_if.slave             uart,
    input  logic                        trigger,
    input  logic                        fft_done,
    input  logic [NUM_CH*VALUE_W-1:0]   max_value,
    output logic [7:0]                  thr_value,
    output logic                        thr_we,
    output logic [7:0]                  freq_value,
    output logic                        freq_we,
    output logic [$clog2(NUM_CH)-1:0]   ch_sel,
    output logic                        busy
);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int NBYTES  = (VALUE_W + 7) / 8;
    localparam int REPLY_W = NBYTES * 8;
    localparam int CNT_W   = $clog2(NBYTES + 1);
    localparam int WDOG_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(NBYTES - 1);

    localparam logic [7:0] OP_SET_THR  = 8'h01;
    localparam logic [7:0] OP_SET_FREQ = 8'h02;
    localparam logic [7:0] OP_READ_MAX = 8'h03;
    localparam logic [7:0] OP_PING     = 8'h04;
    localparam logic [7:0] BYTE_PING   = 8'hA5;
    localparam logic [7:0] BYTE_NAK    = 8'hEE;
`ifdef CMD_DISPATCH_ACK_EN
    localparam logic [7:0] BYTE_ACK    = 8'h06;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ARG,
        ST_EXEC,
        ST_WAIT_TRIG,
        ST_WAIT_FFT,
        ST_SEND
    } state_t;

    state_t               state_reg;
    logic [7:0]           opcode_reg;
    logic [7:0]           arg_reg;
    logic [REPLY_W-1:0]   reply_reg;
    logic [CNT_W-1:0]     bytes_left_reg;
    logic [WDOG_W-1:0]    wdog_reg;
`ifdef CMD_DISPATCH_ACK_EN
    logic                 arm_after_ack_reg;
`endif

    logic [VALUE_W-1:0]   peaks [NUM_CH];
    logic [REPLY_W-1:0]   peak_ext;
    logic                 wdog_expired;
    logic                 ch_ok;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_peak
            assign peaks[gi] = max_value[gi*VALUE_W +: VALUE_W];
        end
    endgenerate

    assign peak_ext     = REPLY_W'(peaks[ch_sel]);
    assign wdog_expired = (wdog_reg == WDOG_LIMIT);
    assign ch_ok        = (32'(arg_reg) < 32'(NUM_CH));
    assign busy         = (state_reg != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            opcode_reg        <= '0;
            arg_reg           <= '0;
            reply_reg         <= '0;
            bytes_left_reg    <= '0;
            wdog_reg          <= '0;
            thr_value         <= '0;
            thr_we            <= 1'b0;
            freq_value        <= '0;
            freq_we           <= 1'b0;
            ch_sel            <= '0;
            uart.tx_data      <= '0;
            uart.tx_valid     <= 1'b0;
            uart.rx_drop      <= 1'b0;
`ifdef CMD_DISPATCH_ACK_EN
            arm_after_ack_reg <= 1'b0;
`endif
        end else begin
            thr_we       <= 1'b0;
            freq_we      <= 1'b0;
            uart.rx_drop <= uart.rx_valid &&
                            (state_reg inside {ST_EXEC, ST_WAIT_TRIG, ST_WAIT_FFT, ST_SEND});

            // Saturating watchdog; transitions into a waiting state clear it explicitly below.
            if (state_reg inside {ST_GET_ARG, ST_WAIT_TRIG, ST_WAIT_FFT}) begin
                if (!wdog_expired) begin
                    wdog_reg <= wdog_reg + 1'b1;
                end
            end else begin
                wdog_reg <= '0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (uart.rx_valid) begin
                        opcode_reg <= uart.rx_data;
                        if (uart.rx_data inside {OP_SET_THR, OP_SET_FREQ, OP_READ_MAX}) begin
                            state_reg <= ST_GET_ARG;
                        end else begin
                            uart.tx_data   <= (uart.rx_data == OP_PING) ? BYTE_PING : BYTE_NAK;
                            uart.tx_valid  <= 1'b1;
                            bytes_left_reg <= '0;
                            state_reg      <= ST_SEND;
                        end
                    end
                end

                ST_GET_ARG: begin
                    if (uart.rx_valid) begin
                        arg_reg   <= uart.rx_data;
                        state_reg <= ST_EXEC;
                    end else if (wdog_expired) begin
                        uart.tx_data   <= BYTE_NAK;
                        uart.tx_valid  <= 1'b1;
                        bytes_left_reg <= '0;
                        state_reg      <= ST_SEND;
                    end
                end

                ST_EXEC: begin
                    if (opcode_reg == OP_SET_THR || opcode_reg == OP_SET_FREQ) begin
                        if (opcode_reg == OP_SET_THR) begin
                            thr_value <= arg_reg;
                            thr_we    <= 1'b1;
                        end else begin
                            freq_value <= arg_reg;
                            freq_we    <= 1'b1;
                        end
`ifdef CMD_DISPATCH_ACK_EN
                        uart.tx_data   <= BYTE_ACK;
                        uart.tx_valid  <= 1'b1;
                        bytes_left_reg <= '0;
                        state_reg      <= ST_SEND;
`else
                        state_reg <= ST_IDLE;
`endif
                    end else if (ch_ok) begin
                        ch_sel <= arg_reg[CH_W-1:0];
`ifdef CMD_DISPATCH_ACK_EN
                        uart.tx_data      <= BYTE_ACK;
                        uart.tx_valid     <= 1'b1;
                        bytes_left_reg    <= '0;
                        arm_after_ack_reg <= 1'b1;
                        state_reg         <= ST_SEND;
`else
                        state_reg <= ST_WAIT_TRIG;
`endif
                    end else begin
                        uart.tx_data   <= BYTE_NAK;
                        uart.tx_valid  <= 1'b1;
                        bytes_left_reg <= '0;
                        state_reg      <= ST_SEND;
                    end
                end

                ST_WAIT_TRIG: begin
                    // A coincident fft_done belongs to an earlier acquisition and is ignored.
                    if (trigger) begin
                        wdog_reg  <= '0;
                        state_reg <= ST_WAIT_FFT;
                    end else if (wdog_expired) begin
                        uart.tx_data   <= BYTE_NAK;
                        uart.tx_valid  <= 1'b1;
                        bytes_left_reg <= '0;
                        state_reg      <= ST_SEND;
                    end
                end

                ST_WAIT_FFT: begin
                    if (fft_done) begin
                        uart.tx_data   <= peak_ext[REPLY_W-1 -: 8];
                        reply_reg      <= peak_ext << 8;
                        uart.tx_valid  <= 1'b1;
                        bytes_left_reg <= LAST_IDX;
                        state_reg      <= ST_SEND;
                    end else if (wdog_expired) begin
                        uart.tx_data   <= BYTE_NAK;
                        uart.tx_valid  <= 1'b1;
                        bytes_left_reg <= '0;
                        state_reg      <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (uart.tx_ready) begin
                        if (bytes_left_reg == '0) begin
                            uart.tx_valid <= 1'b0;
`ifdef CMD_DISPATCH_ACK_EN
                            if (arm_after_ack_reg) begin
                                arm_after_ack_reg <= 1'b0;
                                state_reg         <= ST_WAIT_TRIG;
                            end else
`endif
                            state_reg <= ST_IDLE;
                        end else begin
                            uart.tx_data   <= reply_reg[REPLY_W-1 -: 8];
                            reply_reg      <= reply_reg << 8;
                            bytes_left_reg <= bytes_left_reg - 1'b1;
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_dispatcher.sv
// Self-checking bench for cmd_dispatcher: directed scenarios plus randomized commands against a byte-level model.
module tb_cmd_dispatcher;
    localparam int NUM_CH      = 4;
    localparam int VALUE_W     = 10;
    localparam int TIMEOUT_CYC = 16;
    localparam int NB          = (VALUE_W + 7) / 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      trigger;
    logic                      fft_done;
    logic [NUM_CH*VALUE_W-1:0] max_value;
    logic [7:0]                thr_value;
    logic                      thr_we;
    logic [7:0]                freq_value;
    logic                      freq_we;
    logic [1:0]                ch_sel;
    logic                      busy;

    cmd_dispatcher_if u_if();

    cmd_dispatcher #(
        .NUM_CH      (NUM_CH),
        .VALUE_W     (VALUE_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart       (u_if),
        .trigger    (trigger),
        .fft_done   (fft_done),
        .max_value  (max_value),
        .thr_value  (thr_value),
        .thr_we     (thr_we),
        .freq_value (freq_value),
        .freq_we    (freq_we),
        .ch_sel     (ch_sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         stable_err;
    logic [7:0] m_thr;
    logic [7:0] m_freq;
    int         m_ch;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        tick();
        u_if.rx_valid = 1'b0;
    endtask

    // Accepts up to n reply bytes into got_q; with bp set, tx_ready is randomly withheld.
    task automatic collect(input int n, input bit bp);
        logic [7:0] held = 8'h00;
        bit         pend = 1'b0;
        got_q.delete();
        stable_err = 0;
        for (int c = 0; c < 200 && got_q.size() < n; c++) begin
            if (pend && (u_if.tx_valid !== 1'b1 || u_if.tx_data !== held)) stable_err++;
            u_if.tx_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (u_if.tx_valid && u_if.tx_ready) begin
                got_q.push_back(u_if.tx_data);
                pend = 1'b0;
            end else if (u_if.tx_valid) begin
                pend = 1'b1;
                held = u_if.tx_data;
            end
            tick();
        end
        u_if.tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; trigger = 1'b0; fft_done = 1'b0; max_value = '0;
        u_if.rx_valid = 1'b0; u_if.rx_data = 8'h00; u_if.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        m_thr = 8'h00; m_freq = 8'h00; m_ch = 0;
        n_checks++;
        if ({u_if.tx_valid, thr_we, freq_we, u_if.rx_drop, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %05b expected 00000",
                     {u_if.tx_valid, thr_we, freq_we, u_if.rx_drop, busy});
        end
        n_checks++;
        if ({thr_value, freq_value, u_if.tx_data} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %06h expected 000000", {thr_value, freq_value, u_if.tx_data});
        end
        n_checks++;
        if (ch_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ch_sel: got %0d expected 0", ch_sel);
        end
    endtask

    task automatic test_set_thr();
        send_byte(8'h01);
        send_byte(8'h3C);
        n_checks++;
        if (thr_we !== 1'b0) begin n_fail++; $display("FAIL thr_we_early: got %b expected 0", thr_we); end
        tick();
        n_checks++;
        if (thr_we !== 1'b1 || thr_value !== 8'h3C) begin
            n_fail++;
            $display("FAIL thr_write: got we=%b val=%02h expected we=1 val=3c", thr_we, thr_value);
        end
        tick();
        n_checks++;
        if (thr_we !== 1'b0 || u_if.tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL thr_after: got we=%b tx_valid=%b busy=%b expected 0 0 0", thr_we, u_if.tx_valid, busy);
        end
        m_thr = 8'h3C;
        $display("txn set_thr 3c");
    endtask

    task automatic test_read_max();
        send_byte(8'h03);
        send_byte(8'h02);
        tick();
        n_checks++;
        if (ch_sel !== 2'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_select: got ch_sel=%0d busy=%b expected 2 1", ch_sel, busy);
        end
        m_ch = 2;
        tick();
        trigger = 1'b1; tick(); trigger = 1'b0;
        max_value = 40'($urandom());
        max_value[29:20] = 10'h2B7;
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        n_checks++;
        if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== 8'h02) begin
            n_fail++;
            $display("FAIL read_first_byte: got valid=%b data=%02h expected 1 02", u_if.tx_valid, u_if.tx_data);
        end
        collect(2, 1'b0);
        exp_q = '{8'h02, 8'hB7};
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL read_byte%0d: got %02h expected %02h", i,
                         (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        n_checks++;
        if (u_if.tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_done: got tx_valid=%b busy=%b expected 0 0", u_if.tx_valid, busy);
        end
        $display("txn read_max ch2 reply 02 b7");
    endtask

    task automatic test_trig_fft_together();
        send_byte(8'h03);
        send_byte(8'h02);
        tick();
        max_value[29:20] = 10'h111;
        trigger = 1'b1; fft_done = 1'b1; tick(); trigger = 1'b0; fft_done = 1'b0;
        max_value[29:20] = 10'h0AB;
        repeat (4) tick();
        n_checks++;
        if (u_if.tx_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL together_wait: got tx_valid=%b busy=%b expected 0 1", u_if.tx_valid, busy);
        end
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        max_value[29:20] = 10'h3FF;
        collect(2, 1'b1);
        exp_q = '{8'h00, 8'hAB};
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL together_byte%0d: got %02h expected %02h", i,
                         (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        $display("txn read_max trigger+fft_done together reply 00 ab");
    endtask

    task automatic test_bad_ch();
        send_byte(8'h03);
        send_byte(8'h07);
        collect(1, 1'b0);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hEE) begin
            n_fail++;
            $display("FAIL bad_ch_nak: got %0d bytes first=%02h expected 1 byte ee",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        n_checks++;
        if (int'(ch_sel) !== m_ch) begin
            n_fail++;
            $display("FAIL bad_ch_sel: got %0d expected %0d", ch_sel, m_ch);
        end
        $display("txn read_max ch7 nak");
    endtask

    task automatic test_watchdog();
        send_byte(8'h01);
        repeat (TIMEOUT_CYC) tick();
        n_checks++;
        if (u_if.tx_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_early: got tx_valid=%b busy=%b expected 0 1", u_if.tx_valid, busy);
        end
        tick();
        n_checks++;
        if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== 8'hEE) begin
            n_fail++;
            $display("FAIL wdog_nak: got valid=%b data=%02h expected 1 ee", u_if.tx_valid, u_if.tx_data);
        end
        send_byte(8'h55);
        n_checks++;
        if (u_if.rx_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b expected 1", u_if.rx_drop); end
        tick();
        n_checks++;
        if (u_if.rx_drop !== 1'b0 || u_if.tx_data !== 8'hEE) begin
            n_fail++;
            $display("FAIL drop_end: got drop=%b data=%02h expected 0 ee", u_if.rx_drop, u_if.tx_data);
        end
        collect(1, 1'b0);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hEE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_reply: got %0d bytes busy=%b expected 1 byte ee busy 0", got_q.size(), busy);
        end
        $display("txn set_thr no arg watchdog nak");
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int          kind;
            logic [7:0]  op, arg;
            int unsigned pk;
            kind = $urandom_range(0, 5);
            arg  = 8'($urandom());
            exp_q.delete();
            case (kind)
                0: begin op = 8'h01; m_thr = arg; end
                1: begin op = 8'h02; m_freq = arg; end
                2: begin op = 8'h03; arg = 8'($urandom_range(0, NUM_CH - 1)); end
                3: begin op = 8'h03; arg = 8'($urandom_range(NUM_CH, 255)); exp_q.push_back(8'hEE); end
                4: begin op = 8'h04; exp_q.push_back(8'hA5); end
                default: begin
                    do op = 8'($urandom()); while (op inside {8'h01, 8'h02, 8'h03, 8'h04});
                    exp_q.push_back(8'hEE);
                end
            endcase
            send_byte(op);
            if (kind <= 3) begin
                repeat ($urandom_range(0, 2)) tick();
                send_byte(arg);
            end
            if (kind == 2) begin
                m_ch = int'(arg);
                tick();
                repeat ($urandom_range(0, 3)) tick();
                trigger = 1'b1; tick(); trigger = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
                max_value = 40'({$urandom(), $urandom()});
                pk = 32'((max_value >> (m_ch * VALUE_W)) & ((40'd1 << VALUE_W) - 40'd1));
                for (int b = NB - 1; b >= 0; b--) exp_q.push_back(8'(pk >> (8 * b)));
                fft_done = 1'b1; tick(); fft_done = 1'b0;
                max_value = 40'({$urandom(), $urandom()});
            end
            if (exp_q.size() > 0) collect(exp_q.size(), 1'b1);
            else got_q.delete();
            $display("txn %0d op=%02h arg=%02h reply_bytes=%0d", t, op, arg, got_q.size());
            n_checks++;
            if (got_q.size() != exp_q.size() || stable_err != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_len: got %0d bytes (%0d unstable) expected %0d", t,
                         got_q.size(), stable_err, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_byte%0d: got %02h expected %02h", t, i,
                             (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
                end
            end
            tick(); tick();
            n_checks++;
            if (busy !== 1'b0 || u_if.tx_valid !== 1'b0 || thr_value !== m_thr ||
                freq_value !== m_freq || int'(ch_sel) !== m_ch) begin
                n_fail++;
                $display("FAIL rnd%0d_state: got busy=%b txv=%b thr=%02h freq=%02h ch=%0d expected 0 0 %02h %02h %0d",
                         t, busy, u_if.tx_valid, thr_value, freq_value, ch_sel, m_thr, m_freq, m_ch);
            end
        end
    endtask

    task automatic test_ping_backpressure_reset();
        u_if.tx_ready = 1'b0;
        send_byte(8'h04);
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (u_if.tx_valid !== 1'b1 || u_if.tx_data !== 8'hA5) begin
                n_fail++;
                $display("FAIL ping_hold%0d: got valid=%b data=%02h expected 1 a5", c, u_if.tx_valid, u_if.tx_data);
            end
            tick();
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (u_if.tx_valid !== 1'b0 || busy !== 1'b0 || u_if.tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b busy=%b data=%02h expected 0 0 00",
                     u_if.tx_valid, busy, u_if.tx_data);
        end
        #1 reset = 1'b0;
        m_thr = 8'h00; m_freq = 8'h00; m_ch = 0;
        tick();
        n_checks++;
        if (u_if.tx_valid !== 1'b0 || busy !== 1'b0 || thr_value !== m_thr) begin
            n_fail++;
            $display("FAIL post_reset: got valid=%b busy=%b thr=%02h expected 0 0 00", u_if.tx_valid, busy, thr_value);
        end
        send_byte(8'h04);
        collect(1, 1'b0);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL ping_after_reset: got %0d bytes expected 1 byte a5", got_q.size());
        end
        $display("txn ping backpressure then reset");
    endtask

    initial begin
        test_reset();
        test_set_thr();
        test_read_max();
        test_trig_fft_together();
        test_bad_ch();
        test_watchdog();
        test_random();
        test_ping_backpressure_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Parametrised UART command dispatcher between the UART RX/TX byte interfaces and the acquisition/FFT core. It parses opcode-plus-argument command frames, issues threshold/frequency writes, and selects one of NUM_CH channels. It arms on trigger, snapshots the FFT peak when the FFT completes, and streams it back as multi-byte replies. A watchdog aborts any stalled command with a NAK.

## Interface
Parameters:
- NUM_CH, 4: number of acquisition channels (2..16).
- VALUE_W, 10: bit width of each channel's FFT peak value (1..32).
- TIMEOUT_CYC, 1000000: watchdog limit in clk cycles (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- tx_ready  in  1  UART TX can accept a byte.
- trigger  in  1  acquisition trigger pulse.
- fft_done  in  1  FFT results valid pulse.
- max_value  in  NUM_CH*VALUE_W  packed per-channel peaks; channel k occupies bits [k*VALUE_W +: VALUE_W].
- thr_value  out  8  threshold argument; held until the next write.
- thr_we  out  1  one-cycle threshold write strobe.
- freq_value  out  8  frequency argument; held.
- freq_we  out  1  one-cycle frequency write strobe.
- ch_sel  out  $clog2(NUM_CH)  selected channel.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- busy  out  1  high in every state except IDLE.
- rx_drop  out  1  one-cycle pulse when a byte is discarded.

## Operation
- Opcodes:
  - 0x01 SET_THR arg: thr_value←arg.
  - 0x02 SET_FREQ arg: freq_value←arg.
  - 0x03 READ_MAX ch: ch_sel←ch, then wait for trigger, then wait for fft_done, then reply with the peak.
  - 0x04 PING: reply 0xA5.
  - Any other opcode: reply 0xEE (NAK).
- States:
  - IDLE: valid opcode → GET_ARG (0x01–0x03), or → SEND (PING or unknown).
  - GET_ARG: arg byte → EXEC.
  - EXEC: one cycle; performs the write or the channel check, then → IDLE, WAIT_TRIG, or SEND.
  - WAIT_TRIG: trigger → WAIT_FFT.
  - WAIT_FFT: fft_done → SEND.
  - SEND: after the last byte is accepted → IDLE.
- READ_MAX with ch ≥ NUM_CH: reply NAK; ch_sel is unchanged.
- Reply length:
  - NBYTES = (VALUE_W+7)/8.
  - Value is zero-extended to NBYTES*8 bits and sent MSB byte first.
  - The value is snapshotted from max_value[ch_sel] on the fft_done cycle, so later changes do not corrupt the reply.
- rx_valid in WAIT_TRIG, WAIT_FFT, SEND or EXEC: byte discarded, rx_drop pulses, state unchanged.
- trigger and fft_done together in WAIT_TRIG: only trigger is honoured; the command then waits for a later fft_done.
- trigger in any state other than WAIT_TRIG: ignored. The same applies to fft_done outside WAIT_FFT.
- Watchdog:
  - The counter clears on every state entry and counts cycles spent in GET_ARG, WAIT_TRIG or WAIT_FFT.
  - On reaching TIMEOUT_CYC: abort, reply NAK, → SEND.
  - The watchdog never runs in SEND; a stalled tx_ready holds the block indefinitely.
- Reset values:
  - tx_valid, thr_we, freq_we, rx_drop and busy are 0.
  - thr_value, freq_value and tx_data are 0x00.
  - ch_sel is 0; the state is IDLE.
- Reset mid-operation: outputs return to reset values immediately (asynchronous), and any partial reply is discarded.

## Timing
- Handshake: a byte transfers on a cycle with tx_valid && tx_ready. tx_data must not change while tx_valid=1 and tx_ready=0.
- The next reply byte is presented on the cycle after acceptance. tx_valid stays high across multi-byte replies and deasserts the cycle after the last acceptance.
- PING or unknown opcode on cycle N: tx_valid=1 with the reply byte at N+1.
- Argument byte accepted on cycle N: EXEC at N+1, thr_we/freq_we high at N+2 for exactly one cycle, new value visible at N+2.
- fft_done on cycle N: first peak byte with tx_valid at N+1.
- Watchdog: the NAK appears exactly TIMEOUT_CYC+1 cycles after state entry.
- The watchdog counter is $clog2(TIMEOUT_CYC+1) bits wide and saturates; it never wraps.
- Back-to-back commands: a new opcode is accepted from the first IDLE cycle.

## Configuration
- CMD_DISPATCH_ACK_EN defined: SET_THR, SET_FREQ and a successful READ_MAX channel selection each send 0x06 (ACK) as a one-byte reply. The ACK is presented in the cycle after EXEC; for READ_MAX, WAIT_TRIG is entered only after the ACK is accepted, and a trigger arriving while the ACK is pending is ignored.
- Undefined: set commands and channel selection produce no TX traffic.

## Test plan
- Reset, then bytes 0x01,0x3C → thr_we is a single pulse with thr_value=0x3C; no tx_valid (no ACK).
- Bytes 0x03,0x02; trigger; max_value ch2=0x2B7 (VALUE_W=10); fft_done → ch_sel=2; replies 0x02 then 0xB7; busy low afterwards.
- Bytes 0x03,0x02, then trigger and fft_done together; max_value ch2 changes after a second fft_done 5 cycles later → the reply uses the value sampled on the second fft_done.
- READ_MAX with ch=0x07 (NUM_CH=4) → NAK 0xEE; ch_sel unchanged.
- Opcode 0x01 with no argument and TIMEOUT_CYC=16 → 0xEE at cycle 17; extra byte sent during SEND → rx_drop pulse.
- tx_ready held low 10 cycles during PING → tx_data stable at 0xA5 with tx_valid high. Assert reset mid-reply → tx_valid drops immediately; IDLE after release.
